aes_rr_scheduler: RTL and testbench

AES_RR_SCHEDULER -- requirements
Module: aes_rr_scheduler

---
 rtl/aes_sched_pkg.sv | 19 +
 rtl/aes_tag_pipe.sv | 34 +++
 rtl/aes_rr_scheduler.sv | 130 +++++++++++++
 tb/tb_aes_rr_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared constants and tag format for the two-requester AES core scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_LATENCY_DEF = 21;
  localparam int unsigned BLK_W           = 128;
  localparam int unsigned CNT_W           = 5;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // One tag per core slot: marks whether the slot carries a request and whose it is.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/aes_tag_pipe.sv
// Fixed-depth shift register that travels alongside the AES core pipeline.
module aes_tag_pipe #(
  parameter int unsigned DEPTH = 21,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out = stage_q[DEPTH-1];

endmodule

// File: rtl/aes_rr_scheduler.sv
// Round-robin arbiter sharing one pipelined aes_128 core between requesters A and B.
module aes_rr_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned AES_LATENCY = AES_LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [BLK_W-1:0]   a_state,
  input  logic [BLK_W-1:0]   a_key,
  output logic               a_out_valid,
  output logic [BLK_W-1:0]   a_out,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [BLK_W-1:0]   b_state,
  input  logic [BLK_W-1:0]   b_key,
  output logic               b_out_valid,
  output logic [BLK_W-1:0]   b_out,
  output logic [BLK_W-1:0]   core_state,
  output logic [BLK_W-1:0]   core_key,
  input  logic [BLK_W-1:0]   core_out,
  output logic [CNT_W-1:0]   inflight,
  output logic               busy
);

  logic             prio_q, prio_d;
  logic [BLK_W-1:0] core_state_q, core_state_d;
  logic [BLK_W-1:0] core_key_q, core_key_d;
  logic [BLK_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic             a_out_valid_q, a_out_valid_d, b_out_valid_q, b_out_valid_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  tag_t             ret_q, ret_d;
  tag_t             tag_in, tail_tag;
  logic [TAG_W-1:0] pipe_out;
  logic             accept, retire;

  aes_tag_pipe #(.DEPTH(AES_LATENCY), .W(TAG_W)) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .in  (tag_in),
    .out (pipe_out)
  );

  always_comb begin
    a_ready       = rst && en && a_valid && (!b_valid || prio_q == ID_A);
    b_ready       = rst && en && b_valid && (!a_valid || prio_q == ID_B);
    accept        = a_ready || b_ready;
    tail_tag      = tag_t'(pipe_out);
    retire        = tail_tag.valid;

    prio_d        = prio_q;
    core_state_d  = core_state_q;
    core_key_d    = core_key_q;
    tag_in.valid  = accept;
    tag_in.id     = b_ready ? ID_B : ID_A;
    ret_d         = tail_tag;
    inflight_d    = inflight_q;
    a_out_d       = a_out_q;
    b_out_d       = b_out_q;
    a_out_valid_d = 1'b0;
    b_out_valid_d = 1'b0;

    // Pointer moves to the loser only when both were contending.
    if (a_valid && b_valid && accept) begin
      prio_d = a_ready ? ID_B : ID_A;
    end

    if (a_ready) begin
      core_state_d = a_state;
      core_key_d   = a_key;
    end else if (b_ready) begin
      core_state_d = b_state;
      core_key_d   = b_key;
    end

    // The tail tag is re-timed one stage so it lines up with core_out.
    if (ret_q.valid) begin
      if (ret_q.id == ID_A) begin
        a_out_d       = core_out;
        a_out_valid_d = 1'b1;
      end else begin
        b_out_d       = core_out;
        b_out_valid_d = 1'b1;
      end
    end

    if (accept && !retire) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (retire && !accept) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q        <= ID_A;
      core_state_q  <= '0;
      core_key_q    <= '0;
      ret_q         <= '0;
      inflight_q    <= '0;
      a_out_q       <= '0;
      b_out_q       <= '0;
      a_out_valid_q <= 1'b0;
      b_out_valid_q <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      core_state_q  <= core_state_d;
      core_key_q    <= core_key_d;
      ret_q         <= ret_d;
      inflight_q    <= inflight_d;
      a_out_q       <= a_out_d;
      b_out_q       <= b_out_d;
      a_out_valid_q <= a_out_valid_d;
      b_out_valid_q <= b_out_valid_d;
    end
  end

  assign core_state  = core_state_q;
  assign core_key    = core_key_q;
  assign a_out       = a_out_q;
  assign b_out       = b_out_q;
  assign a_out_valid = a_out_valid_q;
  assign b_out_valid = b_out_valid_q;
  assign inflight    = inflight_q;
  assign busy        = (inflight_q != '0);

endmodule

// File: tb/tb_aes_rr_scheduler.sv
// Scoreboard bench for aes_rr_scheduler with a behavioural 21-stage stand-in for aes_128.
module tb_aes_rr_scheduler;

  localparam int unsigned LAT = 21;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, b_ready;
  logic [127:0] a_state = '0, a_key = '0, b_state = '0, b_key = '0;
  logic         a_out_valid, b_out_valid;
  logic [127:0] a_out, b_out;
  logic [127:0] core_state, core_key, core_out;
  logic [4:0]   inflight;
  logic         busy;

  aes_rr_scheduler #(.AES_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst_n), .en(en),
    .a_valid(a_valid), .a_ready(a_ready), .a_state(a_state), .a_key(a_key),
    .a_out_valid(a_out_valid), .a_out(a_out),
    .b_valid(b_valid), .b_ready(b_ready), .b_state(b_state), .b_key(b_key),
    .b_out_valid(b_out_valid), .b_out(b_out),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: exact for the FIPS-197 vector, otherwise a keyed mix.
  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
  endfunction

  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_f(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    int           exp_cyc;
  } exp_t;

  exp_t         q_a[$], q_b[$];
  int           acc_q[$];
  int           cyc = 0;
  logic         prio_m = 1'b0;
  logic [127:0] last_a = '0, last_b = '0;
  int           max_infl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic ea, eb;
    exp_t e;
    if (!rst_n) begin
      q_a.delete(); q_b.delete(); acc_q.delete();
      prio_m = 1'b0; last_a = '0; last_b = '0;
      check("rst_ready", {126'd0, a_ready, b_ready}, '0);
      check("rst_strobe", {126'd0, a_out_valid, b_out_valid}, '0);
      check("rst_inflight", 128'(inflight), '0);
      check("rst_outs", a_out | b_out | core_state | core_key, '0);
    end else begin
      ea = en && a_valid && (!b_valid || prio_m == 1'b0);
      eb = en && b_valid && (!a_valid || prio_m == 1'b1);
      check("a_ready", 128'(a_ready), 128'(ea));
      check("b_ready", 128'(b_ready), 128'(eb));

      while (acc_q.size() > 0 && acc_q[0] + int'(LAT) <= cyc) void'(acc_q.pop_front());
      check("inflight", 128'(inflight), 128'(acc_q.size()));
      check("busy", 128'(busy), 128'(acc_q.size() != 0));
      if (int'(inflight) > max_infl) max_infl = int'(inflight);

      if (a_out_valid) begin
        if (q_a.size() == 0) check("a_spurious_strobe", 128'(cyc), '1);
        else begin
          e = q_a.pop_front();
          check("a_data", a_out, e.data);
          check("a_latency", 128'(cyc), 128'(e.exp_cyc));
          last_a = e.data;
        end
      end else if (q_a.size() > 0 && q_a[0].exp_cyc <= cyc) begin
        e = q_a.pop_front();
        check("a_missed_strobe", 128'(cyc), 128'(e.exp_cyc));
      end
      check("a_out_hold", a_out, last_a);

      if (b_out_valid) begin
        if (q_b.size() == 0) check("b_spurious_strobe", 128'(cyc), '1);
        else begin
          e = q_b.pop_front();
          check("b_data", b_out, e.data);
          check("b_latency", 128'(cyc), 128'(e.exp_cyc));
          last_b = e.data;
        end
      end else if (q_b.size() > 0 && q_b[0].exp_cyc <= cyc) begin
        e = q_b.pop_front();
        check("b_missed_strobe", 128'(cyc), 128'(e.exp_cyc));
      end
      check("b_out_hold", b_out, last_b);

      // Acceptance happens on the coming edge; the strobe follows LAT+1 edges later.
      if (ea) begin
        q_a.push_back('{data: core_f(a_state, a_key), exp_cyc: cyc + 1 + int'(LAT) + 1});
        acc_q.push_back(cyc + 1);
        if (b_valid) prio_m = 1'b1;
      end else if (eb) begin
        q_b.push_back('{data: core_f(b_state, b_key), exp_cyc: cyc + 1 + int'(LAT) + 1});
        acc_q.push_back(cyc + 1);
        if (a_valid) prio_m = 1'b0;
      end
    end
  end

  task automatic step(input logic av, input logic bv, input logic e);
    @(posedge clk); #1;
    a_valid = av; b_valid = bv; en = e;
    a_state = {$urandom, $urandom, $urandom, $urandom};
    a_key   = {$urandom, $urandom, $urandom, $urandom};
    b_state = {$urandom, $urandom, $urandom, $urandom};
    b_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_dut(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b1;

    // Single FIPS-197 request from A.
    @(posedge clk); #1;
    a_valid = 1'b1; a_state = FIPS_PT; a_key = FIPS_KEY; b_valid = 1'b0; en = 1'b1;
    idle(30);

    // Contention straight out of reset.
    reset_dut(2);
    repeat (10) step(1'b1, 1'b1, 1'b1);
    idle(30);

    // Streaming from A alone; inflight saturates.
    reset_dut(1);
    max_infl = 0;
    repeat (30) step(1'b1, 1'b0, 1'b1);
    idle(30);
    check("max_inflight", 128'(max_infl), 128'(LAT));

    // Enable gating while earlier results retire.
    repeat (5) step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(30);

    // Reset with three requests in flight.
    reset_dut(1);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    idle(4);
    @(posedge clk); #1 rst_n = 1'b0; a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(30);
    check("post_rst_inflight", 128'(inflight), '0);

    // Lone requester A while the pointer favours B.
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    idle(30);

    @(negedge clk);
    check("q_a_drained", 128'(q_a.size()), '0);
    check("q_b_drained", 128'(q_b.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
